// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the 6502 bus controller: sequencer states,
// reset-vector addresses/data and the read-source tags of the CPU read pipe.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        LOAD     = 2'd2
    } bus_state_t;

    typedef enum logic [2:0] {
        SRC_ZERO = 3'd0,
        SRC_RAM  = 3'd1,
        SRC_LED  = 3'd2,
        SRC_VLO  = 3'd3,
        SRC_VHI  = 3'd4
    } rd_src_t;

    localparam logic [15:0] VEC_LO      = 16'hFFFC;
    localparam logic [15:0] VEC_HI      = 16'hFFFD;
    localparam logic [7:0]  VEC_LO_DATA = 8'h00;
    localparam logic [7:0]  VEC_HI_DATA = 8'hAA;

endpackage

// File: rtl/cpu_bus_ctrl_ce_gen.sv
// CPU clock-enable generator: one single-clk cpu_ce pulse every CPU_DIV clks.
module cpu_ce_gen #(
    parameter int CPU_DIV = 1350000
) (
    input  logic clk,
    input  logic reset,
    output logic cpu_ce
);

    localparam int CW = (CPU_DIV > 2) ? $clog2(CPU_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CPU_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign cpu_ce = (div_cnt == DIV_LAST);

endmodule

// File: rtl/cpu_bus_ctrl.sv
// 6502 bus controller: reset/load sequencer, address decode onto RAM/LED/vector,
// and CPU-priority arbitration of the single-port program RAM with the UART loader.
module cpu_bus_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int          CPU_DIV      = 1350000,
    parameter int          RESET_CYCLES = 3,
    parameter int          RAM_AW       = 9,
    parameter logic [15:0] RAM_BASE     = 16'hAA00,
    parameter logic [15:0] LED_ADDR     = 16'h4000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              cpu_ce,
    output logic              cpu_reset,
    input  logic [15:0]       cpu_ab,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_do,
    output logic [7:0]        cpu_di,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              ld_mode,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [RAM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [7:0]        ld_rdata,
    output logic [5:0]        led
);

    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES - 1);
    localparam logic [15:0]    RAM_MASK = 16'((32'd1 << RAM_AW) - 1);

    bus_state_t     state, state_nxt;
    logic [RCW-1:0] rst_cnt, rst_cnt_nxt;

    logic    cpu_acc, ram_hit, led_hit;
    logic    cpu_ram_wr;
    rd_src_t rd_src_p0;
    rd_src_t rd_src_p1;
    logic    rd_vld_p1;

    cpu_ce_gen #(
        .CPU_DIV (CPU_DIV)
    ) u_ce_gen (
        .clk    (clk),
        .reset  (reset),
        .cpu_ce (cpu_ce)
    );

    // Address decode; the RAM window wins if LED_ADDR ever overlaps it.
    assign ram_hit    = ((cpu_ab & ~RAM_MASK) == RAM_BASE);
    assign led_hit    = (cpu_ab == LED_ADDR);
    assign cpu_acc    = cpu_ce & (state != LOAD) & ~reset;
    assign cpu_ram_wr = cpu_acc & cpu_we & ram_hit;
    assign ld_gnt     = ld_req & ~cpu_ce & ~reset;

    always_comb begin
        ram_addr  = ld_addr;
        ram_we    = ld_gnt & ld_we;
        ram_wdata = ld_wdata;
        if (cpu_acc && ram_hit) begin
            ram_addr  = cpu_ab[RAM_AW-1:0];
            ram_we    = cpu_ram_wr;
            ram_wdata = cpu_do;
        end
    end

    always_comb begin
        if (ram_hit) begin
            rd_src_p0 = SRC_RAM;
        end else if (led_hit) begin
            rd_src_p0 = SRC_LED;
        end else if (cpu_ab == VEC_LO) begin
            rd_src_p0 = SRC_VLO;
        end else if (cpu_ab == VEC_HI) begin
            rd_src_p0 = SRC_VHI;
        end else begin
            rd_src_p0 = SRC_ZERO;
        end
    end

    // ---- p0 -> p1: CPU read issued on cpu_ce, RAM data arrives next clk ----
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= cpu_acc & ~cpu_we;
        end
    end

    always_ff @(posedge clk) begin
        rd_src_p1 <= rd_src_p0;
    end

    // ---- p1 -> cpu_di ----
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_di <= 8'h00;
        end else if (rd_vld_p1) begin
            case (rd_src_p1)
                SRC_RAM: cpu_di <= ram_rdata;
                SRC_LED: cpu_di <= {2'b00, ~led};
                SRC_VLO: cpu_di <= VEC_LO_DATA;
                SRC_VHI: cpu_di <= VEC_HI_DATA;
                default: cpu_di <= 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led <= 6'h3F;
        end else if (cpu_acc && cpu_we && led_hit && !ram_hit) begin
            led <= ~cpu_do[5:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_rvalid <= 1'b0;
        end else begin
            ld_rvalid <= ld_gnt & ~ld_we;
        end
    end

    assign ld_rdata = ld_rvalid ? ram_rdata : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RST_HOLD;
            rst_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rst_cnt <= rst_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        case (state)
            RST_HOLD: begin
                if (ld_mode) begin
                    state_nxt   = LOAD;
                    rst_cnt_nxt = '0;
                end else if (cpu_ce) begin
                    if (rst_cnt == RST_LAST) begin
                        state_nxt   = RUN;
                        rst_cnt_nxt = '0;
                    end else begin
                        rst_cnt_nxt = rst_cnt + 1'b1;
                    end
                end
            end
            RUN: begin
                if (ld_mode) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (!ld_mode) begin
                    state_nxt   = RST_HOLD;
                    rst_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = RST_HOLD;
                rst_cnt_nxt = '0;
            end
        endcase
    end

    assign cpu_reset = (state != RUN);

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Bench for cpu_bus_ctrl: behavioural model compared every cycle plus directed literal checks.
module tb_cpu_bus_ctrl;

    localparam int DIV = 4;
    localparam int RC  = 3;
    localparam int MD_HOLD = 0;
    localparam int MD_RUN  = 1;
    localparam int MD_LOAD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_ce, cpu_reset;
    logic [15:0] cpu_ab = 16'h0000;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_do = 8'h00;
    logic [7:0] cpu_di;
    logic [8:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       ld_mode = 1'b0;
    logic       ld_req = 1'b0;
    logic       ld_we = 1'b0;
    logic [8:0] ld_addr = 9'h000;
    logic [7:0] ld_wdata = 8'h00;
    logic       ld_gnt, ld_rvalid;
    logic [7:0] ld_rdata;
    logic [5:0] led;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    cpu_bus_ctrl #(
        .CPU_DIV      (DIV),
        .RESET_CYCLES (RC),
        .RAM_AW       (9),
        .RAM_BASE     (16'hAA00),
        .LED_ADDR     (16'h4000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ce    (cpu_ce),
        .cpu_reset (cpu_reset),
        .cpu_ab    (cpu_ab),
        .cpu_we    (cpu_we),
        .cpu_do    (cpu_do),
        .cpu_di    (cpu_di),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ld_mode   (ld_mode),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .ld_rvalid (ld_rvalid),
        .ld_rdata  (ld_rdata),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Synchronous program RAM, read-before-write.
    logic [7:0] ram [512];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // Behavioural model state.
    int         m_cnt, m_mode, m_hold;
    logic [5:0] m_led;
    logic [7:0] m_di, m_rd_val, m_ld_val;
    bit         m_rd_pend, m_ld_rv;
    logic [7:0] exp_mem [512];

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram[i]     = i[7:0] ^ 8'h5A;
            exp_mem[i] = i[7:0] ^ 8'h5A;
        end
    end

    function automatic bit in_ram(input logic [15:0] a);
        return (a >> 9) == (16'hAA00 >> 9);
    endfunction

    always @(posedge clk) begin : model
        bit ce, acc;
        if (reset) begin
            m_cnt = 0; m_mode = MD_HOLD; m_hold = 0; m_led = 6'h3F;
            m_di = 8'h00; m_rd_pend = 0; m_ld_rv = 0;
        end else begin
            ce  = (m_cnt == DIV - 1);
            acc = ce && (m_mode != MD_LOAD);
            if (m_rd_pend) m_di = m_rd_val;
            m_rd_pend = 0;
            m_ld_rv = 0;
            if (acc) begin
                if (in_ram(cpu_ab)) begin
                    if (cpu_we) exp_mem[cpu_ab[8:0]] = cpu_do;
                    else begin m_rd_pend = 1; m_rd_val = exp_mem[cpu_ab[8:0]]; end
                end else if (cpu_ab == 16'h4000) begin
                    if (cpu_we) m_led = ~cpu_do[5:0];
                    else begin m_rd_pend = 1; m_rd_val = {2'b00, ~m_led}; end
                end else if (!cpu_we) begin
                    m_rd_pend = 1;
                    m_rd_val = (cpu_ab == 16'hFFFD) ? 8'hAA : 8'h00;
                end
            end else if (ld_req && !ce) begin
                if (ld_we) exp_mem[ld_addr] = ld_wdata;
                else begin m_ld_rv = 1; m_ld_val = exp_mem[ld_addr]; end
            end
            case (m_mode)
                MD_HOLD: if (ld_mode) m_mode = MD_LOAD;
                         else if (ce) begin
                             if (m_hold == RC - 1) m_mode = MD_RUN;
                             else m_hold++;
                         end
                MD_RUN:  if (ld_mode) m_mode = MD_LOAD;
                default: if (!ld_mode) begin m_mode = MD_HOLD; m_hold = 0; end
            endcase
            m_cnt = (m_cnt + 1) % DIV;
        end
    end

    always @(negedge clk) begin : compare
        bit ce, acc, gnt, e_we;
        if (chk_en) begin
            ce   = (m_cnt == DIV - 1);
            acc  = ce && (m_mode != MD_LOAD) && !reset;
            gnt  = ld_req && !ce && !reset;
            e_we = (acc && cpu_we && in_ram(cpu_ab)) || (gnt && ld_we);
            chk("m_cpu_ce", 32'(cpu_ce), 32'(ce));
            chk("m_cpu_reset", 32'(cpu_reset), 32'(m_mode != MD_RUN));
            chk("m_led", 32'(led), 32'(m_led));
            chk("m_cpu_di", 32'(cpu_di), 32'(m_di));
            chk("m_ld_gnt", 32'(ld_gnt), 32'(gnt));
            chk("m_ld_rvalid", 32'(ld_rvalid), 32'(m_ld_rv));
            chk("m_ld_rdata", 32'(ld_rdata), m_ld_rv ? 32'(m_ld_val) : 32'h0);
            chk("m_ram_we", 32'(ram_we), 32'(e_we));
            if (acc && in_ram(cpu_ab)) chk("m_ram_addr_cpu", 32'(ram_addr), 32'(cpu_ab[8:0]));
            else if (gnt) chk("m_ram_addr_ld", 32'(ram_addr), 32'(ld_addr));
            if (e_we) chk("m_ram_wdata", 32'(ram_wdata), acc ? 32'(cpu_do) : 32'(ld_wdata));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_ce();
        int n = 0;
        while (cpu_ce !== 1'b1 && n < 20) begin step(); n++; end
        chk("ce_wait", 32'(cpu_ce), 32'h1);
    endtask

    // CPU access placed in the next cpu_ce clk; returns one clk later.
    task automatic cpu_op(input logic [15:0] ab, input logic we, input logic [7:0] d,
                          output logic we_seen, output logic [8:0] addr_seen);
        wait_ce();
        cpu_ab = ab; cpu_we = we; cpu_do = d;
        #1;
        we_seen = ram_we; addr_seen = ram_addr;
        step();
        cpu_we = 1'b0;
    endtask

    initial begin : stim
        logic       ws;
        logic [8:0] as;
        int n, nce;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("rst_led", 32'(led), 32'h3F);
        chk("rst_cpu_di", 32'(cpu_di), 32'h00);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        reset = 1'b0;
        n = 0;
        while (cpu_reset === 1'b1 && n < 40) begin step(); n++; end
        chk("rst_release_clks", 32'(n), 32'd12);

        wait_ce(); step(); n = 1;
        while (cpu_ce !== 1'b1 && n < 20) begin step(); n++; end
        chk("ce_period", 32'(n), 32'd4);

        cpu_op(16'hFFFC, 1'b0, 8'h00, ws, as); step();
        chk("vec_lo", 32'(cpu_di), 32'h00);
        cpu_op(16'hFFFD, 1'b0, 8'h00, ws, as); step();
        chk("vec_hi", 32'(cpu_di), 32'hAA);

        cpu_op(16'h4000, 1'b1, 8'h05, ws, as);
        chk("led_write", 32'(led), 32'h3A);
        cpu_op(16'h4000, 1'b0, 8'h00, ws, as); step();
        chk("led_read", 32'(cpu_di), 32'h05);

        cpu_op(16'hAA05, 1'b1, 8'h69, ws, as);
        chk("ram_wr_we", 32'(ws), 32'h1);
        chk("ram_wr_addr", 32'(as), 32'h005);
        cpu_op(16'hAA05, 1'b0, 8'h00, ws, as); step();
        chk("ram_rd", 32'(cpu_di), 32'h69);

        // Loader read colliding with cpu_ce.
        wait_ce();
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 9'h010;
        #1 chk("ld_collide_gnt", 32'(ld_gnt), 32'h0);
        step();
        chk("ld_retry_gnt", 32'(ld_gnt), 32'h1);
        step();
        ld_req = 1'b0;
        chk("ld_rvalid", 32'(ld_rvalid), 32'h1);
        chk("ld_rdata", 32'(ld_rdata), 32'h4A);

        // Loader write, then CPU reads it back.
        wait_ce(); step();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 9'h020; ld_wdata = 8'h33;
        #1 chk("ld_wr_gnt", 32'(ld_gnt), 32'h1);
        chk("ld_wr_we", 32'(ram_we), 32'h1);
        step();
        ld_req = 1'b0; ld_we = 1'b0;
        cpu_op(16'hAA20, 1'b0, 8'h00, ws, as); step();
        chk("ld_wr_readback", 32'(cpu_di), 32'h33);

        // Load mode.
        ld_mode = 1'b1;
        step();
        chk("load_cpu_reset", 32'(cpu_reset), 32'h1);
        cpu_op(16'h4000, 1'b1, 8'h3F, ws, as);
        chk("load_led_kept", 32'(led), 32'h3A);
        chk("load_no_ram_we", 32'(ws), 32'h0);
        ld_mode = 1'b0;
        step();
        n = 0; nce = 0;
        while (cpu_reset === 1'b1 && n < 100) begin
            if (cpu_ce === 1'b1) nce++;
            step(); n++;
        end
        chk("load_exit_ces", 32'(nce), 32'd3);

        // Reset arriving mid-access while in LOAD.
        cpu_op(16'h4000, 1'b0, 8'h00, ws, as); step(); step();
        ld_mode = 1'b1;
        step(); step();
        wait_ce();
        reset = 1'b1; ld_req = 1'b1; ld_we = 1'b1; cpu_ab = 16'hAA07; cpu_we = 1'b1; cpu_do = 8'h15;
        #1 chk("midrst_ram_we", 32'(ram_we), 32'h0);
        chk("midrst_ld_gnt", 32'(ld_gnt), 32'h0);
        step();
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("midrst_led", 32'(led), 32'h3F);
        chk("midrst_cpu_di", 32'(cpu_di), 32'h00);
        chk("midrst_ld_rvalid", 32'(ld_rvalid), 32'h0);
        chk("midrst_cpu_ce", 32'(cpu_ce), 32'h0);
        reset = 1'b0; ld_mode = 1'b0; ld_req = 1'b0; ld_we = 1'b0; cpu_we = 1'b0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
